// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: issues single-port RAM reads/writes for load/store
// instructions, stalls upstream while an access is in flight, emits one writeback beat per instruction.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemToReg,
  input  logic              RegWrite,
  input  logic [4:0]        rd_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_regwrite,
  output logic              err
);

  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  lat_alu;
  logic [4:0]         lat_rd;
  logic               lat_mtr;
  logic               lat_rw;
  logic               rd_done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (valid_in && MemRead)       state_nxt = RD_WAIT;
        else if (valid_in && MemWrite) state_nxt = WR;
      end
      RD_WAIT: if (rd_done) state_nxt = RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The counter reaches zero in the cycle mem_rdata is valid (RD_LAT cycles after mem_re).
  always_comb begin
    rd_done = (state == RD_WAIT) && (cnt == '0);
    stall   = !rst && (((state == IDLE) && valid_in && (MemRead || MemWrite))
                       || (state == RD_WAIT) || (state == WR));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      lat_alu     <= '0;
      lat_rd      <= '0;
      lat_mtr     <= 1'b0;
      lat_rw      <= 1'b0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
      err         <= 1'b0;
    end else begin
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && MemRead) begin
            lat_alu  <= alu_result;
            lat_rd   <= rd_in;
            lat_mtr  <= MemToReg;
            lat_rw   <= RegWrite;
            mem_addr <= alu_result[ADDR_W-1:0];
            mem_re   <= 1'b1;
            cnt      <= CNT_W'(RD_LAT);
            if (MemWrite) err <= 1'b1;
          end else if (valid_in && MemWrite) begin
            lat_alu   <= alu_result;
            lat_rd    <= rd_in;
            mem_addr  <= alu_result[ADDR_W-1:0];
            mem_wdata <= store_data;
            mem_we    <= 1'b1;
          end else if (valid_in) begin
            wb_valid    <= 1'b1;
            wb_data     <= alu_result;
            wb_rd       <= rd_in;
            wb_regwrite <= RegWrite;
          end
        end
        RD_WAIT: begin
          if (rd_done) begin
            wb_valid    <= 1'b1;
            wb_data     <= lat_mtr ? mem_rdata : lat_alu;
            wb_rd       <= lat_rd;
            wb_regwrite <= lat_rw;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR: begin
          wb_valid    <= 1'b1;
          wb_data     <= lat_alu;
          wb_rd       <= lat_rd;
          wb_regwrite <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of ALU pass-through vectors plus
// hand-written load/store/reset/error sequences against a small RAM model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, MemRead, MemWrite, MemToReg, RegWrite;
  logic [4:0]  rd_in;
  logic [31:0] alu_result, store_data;
  logic        stall, mem_re, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .rd_in(rd_in), .alu_result(alu_result),
    .store_data(store_data), .stall(stall), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .err(err)
  );

  // RAM model: read data appears two cycles after the mem_re cycle, garbage otherwise.
  logic [31:0] ram [256];
  logic [1:0]  re_p;
  logic [15:0] a_p1, a_p2;

  always @(posedge clk) begin
    re_p <= {re_p[0], mem_re};
    a_p1 <= mem_addr;
    a_p2 <= a_p1;
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
  end

  assign mem_rdata = re_p[1] ? ram[a_p2[7:0]] : 32'hBAD0_BAD0;

  typedef struct {
    logic        valid, rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        exp_wbv;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic        exp_rw;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic mr, input logic mw, input logic mtr,
                        input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] sd);
    valid_in = v; MemRead = mr; MemWrite = mw; MemToReg = mtr; RegWrite = rw;
    rd_in = rd; alu_result = alu; store_data = sd;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    re_p = '0; a_p1 = '0; a_p2 = '0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h10] = 32'hDEAD_BEEF;
    ram[8'h30] = 32'hCAFE_F00D;
    ram[8'h11] = 32'h5555_AAAA;

    vecs[0] = '{1'b1, 1'b1, 5'd1,  32'd5,         1'b1, 32'd5,         5'd1,  1'b1};
    vecs[1] = '{1'b1, 1'b1, 5'd2,  32'd6,         1'b1, 32'd6,         5'd2,  1'b1};
    vecs[2] = '{1'b1, 1'b1, 5'd3,  32'd7,         1'b1, 32'd7,         5'd3,  1'b1};
    vecs[3] = '{1'b0, 1'b1, 5'd9,  32'd99,        1'b0, 32'd7,         5'd3,  1'b1};
    vecs[4] = '{1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0};

    // Test 1: reset with random inputs
    rst = 1'b1;
    set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom), $urandom, $urandom);
    step();
    step();
    check("rst_stall", stall, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_regwrite", wb_regwrite, 0);
    check("rst_err", err, 0);
    idle_in();
    rst = 1'b0;
    step();

    // Test 4: back-to-back ALU ops and idle holds
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].valid, 1'b0, 1'b0, 1'b0, vecs[i].rw, vecs[i].rd, vecs[i].alu, 32'd0);
      #1;
      check($sformatf("alu%0d_stall", i), stall, 0);
      step();
      check($sformatf("alu%0d_wb_valid", i), wb_valid, vecs[i].exp_wbv);
      check($sformatf("alu%0d_wb_data", i), wb_data, vecs[i].exp_data);
      check($sformatf("alu%0d_wb_rd", i), wb_rd, vecs[i].exp_rd);
      check($sformatf("alu%0d_wb_regwrite", i), wb_regwrite, vecs[i].exp_rw);
    end
    idle_in();
    step();

    // Test 2: load 0x10 -> rd 3
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h10, 32'h0);
    #1;
    check("ld_c0_stall", stall, 1);
    check("ld_c0_mem_re", mem_re, 0);
    step();
    check("ld_c1_mem_re", mem_re, 1);
    check("ld_c1_mem_addr", mem_addr, 32'h10);
    check("ld_c1_stall", stall, 1);
    check("ld_c1_wb_valid", wb_valid, 0);
    step();
    check("ld_c2_mem_re", mem_re, 0);
    check("ld_c2_stall", stall, 1);
    step();
    check("ld_c3_stall", stall, 1);
    check("ld_c3_wb_valid", wb_valid, 0);
    step();
    check("ld_c4_wb_valid", wb_valid, 1);
    check("ld_c4_wb_data", wb_data, 32'hDEAD_BEEF);
    check("ld_c4_wb_rd", wb_rd, 3);
    check("ld_c4_wb_regwrite", wb_regwrite, 1);
    check("ld_c4_stall", stall, 0);
    step();
    idle_in();
    #1;
    check("ld_c5_wb_valid", wb_valid, 0);
    check("ld_c5_wb_data_hold", wb_data, 32'hDEAD_BEEF);
    check("ld_c5_mem_re", mem_re, 0);

    // Load with MemToReg=0 returns the ALU result
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h11, 32'h0);
    for (int i = 0; i < 4; i++) step();
    check("ldalu_wb_valid", wb_valid, 1);
    check("ldalu_wb_data", wb_data, 32'h11);
    check("ldalu_wb_rd", wb_rd, 9);
    step();
    idle_in();

    // Test 3: store 0x12345678 to 0x20
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h20, 32'h1234_5678);
    #1;
    check("st_c0_stall", stall, 1);
    step();
    check("st_c1_mem_we", mem_we, 1);
    check("st_c1_mem_addr", mem_addr, 32'h20);
    check("st_c1_mem_wdata", mem_wdata, 32'h1234_5678);
    check("st_c1_mem_re", mem_re, 0);
    check("st_c1_stall", stall, 1);
    step();
    check("st_c2_wb_valid", wb_valid, 1);
    check("st_c2_wb_regwrite", wb_regwrite, 0);
    check("st_c2_wb_rd", wb_rd, 7);
    check("st_c2_mem_we", mem_we, 0);
    check("st_c2_stall", stall, 0);
    check("st_ram", ram[8'h20], 32'h1234_5678);
    step();
    idle_in();
    #1;
    check("st_c3_wb_valid", wb_valid, 0);
    check("st_c3_mem_addr_hold", mem_addr, 32'h20);
    check("st_c3_mem_wdata_hold", mem_wdata, 32'h1234_5678);

    // Test 5: load aborted by reset in C2
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h10, 32'h0);
    step();
    check("ab_c1_mem_re", mem_re, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_in();
    #1;
    check("ab_c3_stall", stall, 0);
    check("ab_c3_wb_valid", wb_valid, 0);
    check("ab_c3_wb_data", wb_data, 0);
    step();
    check("ab_c4_wb_valid", wb_valid, 0);
    check("ab_c4_wb_data", wb_data, 0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h77, 32'h0);
    step();
    check("ab_alu_wb_valid", wb_valid, 1);
    check("ab_alu_wb_data", wb_data, 32'h77);
    check("ab_alu_wb_rd", wb_rd, 12);
    idle_in();
    step();

    // Test 6: MemRead and MemWrite together
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h30, 32'hFFFF_0000);
    #1;
    check("rw_c0_err", err, 0);
    step();
    check("rw_c1_mem_re", mem_re, 1);
    check("rw_c1_mem_we", mem_we, 0);
    check("rw_c1_mem_addr", mem_addr, 32'h30);
    check("rw_c1_err", err, 1);
    step();
    check("rw_c2_mem_we", mem_we, 0);
    step();
    check("rw_c3_mem_we", mem_we, 0);
    step();
    check("rw_c4_wb_valid", wb_valid, 1);
    check("rw_c4_wb_data", wb_data, 32'hCAFE_F00D);
    check("rw_c4_wb_rd", wb_rd, 4);
    step();
    idle_in();
    check("rw_ram_untouched", ram[8'h30], 32'hCAFE_F00D);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd1, 32'h0);
    step();
    idle_in();
    check("rw_err_sticky", err, 1);
    step();
    check("rw_err_sticky2", err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rw_err_cleared", err, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
